// File: rtl/xor_frame_pkg.sv
// Shared definitions for the XOR frame checker: default sizes and FSM state encoding.
package xor_frame_pkg;

    localparam int XF_WIDTH     = 32;
    localparam int XF_CNT_W     = 8;
    localparam int XF_MAX_WORDS = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/xor_frame_accum.sv
// Running XOR accumulator with a payload word counter that saturates at MAX_WORDS.
// Priority: clear > load > en. load starts a new frame with its first word.
module xor_frame_accum
    import xor_frame_pkg::*;
#(
    parameter int WIDTH     = XF_WIDTH,
    parameter int CNT_W     = XF_CNT_W,
    parameter int MAX_WORDS = XF_MAX_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] accum,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    assign at_max = (count == CNT_W'(MAX_WORDS));

    // Fold accepted payload words into the running XOR and count them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            accum <= '0;
            count <= '0;
        end else if (clear) begin
            accum <= '0;
            count <= '0;
        end else if (load) begin
            accum <= data;
            count <= CNT_W'(1);
        end else if (en) begin
            accum <= accum ^ data;
            if (!at_max) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/xor_frame_checker.sv
// Receive-side checker for XOR-checksummed word frames.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for the first word of a frame (accum/count are 0)
//   ST_ACCUM  | folding payload words into the running XOR
//   ST_DRAIN  | payload exceeded MAX_WORDS; discard words until in_last
//   ST_REPORT | one-cycle result slot: done=1, in_ready=0, accumulator cleared
//
// Result registers load on the in_last handshake edge, so they are valid
// together with done in ST_REPORT and then hold until the next frame.
module xor_frame_checker
    import xor_frame_pkg::*;
#(
    parameter int WIDTH     = XF_WIDTH,
    parameter int MAX_WORDS = XF_MAX_WORDS,
    parameter int CNT_W     = XF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             done,
    output logic             pass,
    output logic             err_ovf,
    output logic [CNT_W-1:0] word_count,
    output logic [WIDTH-1:0] checksum
);

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               acc_clear;
    logic               acc_load;
    logic               acc_en;
    logic               res_load;
    logic               res_pass;
    logic               res_ovf;
    logic [WIDTH-1:0]   accum;
    logic [CNT_W-1:0]   count;
    logic               at_max;

    assign in_ready = (state_q != ST_REPORT);
    assign accept   = in_valid && in_ready;

    xor_frame_accum #(
        .WIDTH     (WIDTH),
        .CNT_W     (CNT_W),
        .MAX_WORDS (MAX_WORDS)
    ) u_accum (
        .clk    (clk),
        .reset  (reset),
        .clear  (acc_clear),
        .load   (acc_load),
        .en     (acc_en),
        .data   (in_data),
        .accum  (accum),
        .count  (count),
        .at_max (at_max)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and accumulator / result control strobes.
    always_comb begin
        state_d   = state_q;
        acc_clear = 1'b0;
        acc_load  = 1'b0;
        acc_en    = 1'b0;
        res_load  = 1'b0;
        res_pass  = 1'b0;
        res_ovf   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_last) begin
                        // Empty payload: the checksum word itself must be zero.
                        res_load = 1'b1;
                        res_pass = (in_data == '0);
                        state_d  = ST_REPORT;
                    end else begin
                        acc_load = 1'b1;
                        state_d  = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        res_load = 1'b1;
                        res_pass = ((accum ^ in_data) == '0);
                        state_d  = ST_REPORT;
                    end else if (at_max) begin
                        // Overflow: accum and count stay frozen at the first MAX_WORDS words.
                        state_d = ST_DRAIN;
                    end else begin
                        acc_en = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && in_last) begin
                    res_load = 1'b1;
                    res_ovf  = 1'b1;
                    state_d  = ST_REPORT;
                end
            end
            ST_REPORT: begin
                acc_clear = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result registers: captured on the in_last handshake, held until the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done       <= 1'b0;
            pass       <= 1'b0;
            err_ovf    <= 1'b0;
            word_count <= '0;
            checksum   <= '0;
        end else begin
            done <= res_load;
            if (res_load) begin
                pass       <= res_pass;
                err_ovf    <= res_ovf;
                word_count <= count;
                checksum   <= accum;
            end
        end
    end

endmodule

// File: tb/tb_xor_frame_checker.sv
// Scoreboard bench for xor_frame_checker (MAX_WORDS=4 so overflow is reachable).
module tb_xor_frame_checker;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;
    localparam int MAXW  = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             done;
    logic             pass;
    logic             err_ovf;
    logic [CNT_W-1:0] word_count;
    logic [WIDTH-1:0] checksum;

    xor_frame_checker #(
        .WIDTH     (WIDTH),
        .MAX_WORDS (MAXW),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .done       (done),
        .pass       (pass),
        .err_ovf    (err_ovf),
        .word_count (word_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic             pass;
        logic             ovf;
        logic [CNT_W-1:0] wc;
        logic [WIDTH-1:0] ck;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] pay[$];
    int               checks = 0;
    int               failures = 0;
    int               last_acc_cyc = -10;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Frame-level reference: XOR of (at most MAXW) payload words against the checksum word.
    function automatic exp_t model(input logic [WIDTH-1:0] ck);
        exp_t             e;
        logic [WIDTH-1:0] x;
        int               n;
        x = '0;
        n = pay.size();
        for (int i = 0; i < n && i < MAXW; i++) x = x ^ pay[i];
        if (n > MAXW) begin
            e.pass = 1'b0;
            e.ovf  = 1'b1;
            e.wc   = CNT_W'(MAXW);
        end else begin
            e.pass = ((x ^ ck) == '0);
            e.ovf  = 1'b0;
            e.wc   = CNT_W'(n);
        end
        e.ck  = x;
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: pops the scoreboard on done, otherwise checks held results and in_ready.
    exp_t held;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            chk("rst_in_ready", 64'(in_ready), 64'(1));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_pass", 64'(pass), 64'(0));
            chk("rst_err_ovf", 64'(err_ovf), 64'(0));
            chk("rst_word_count", 64'(word_count), 64'(0));
            chk("rst_checksum", 64'(checksum), 64'(0));
            held.pass = 1'b0;
            held.ovf  = 1'b0;
            held.wc   = '0;
            held.ck   = '0;
        end else begin
            chk("in_ready", 64'(in_ready), (cyc == last_acc_cyc) ? 64'(0) : 64'(1));
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 64'(done), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk("done_latency", 64'(cyc), 64'(e.cyc));
                    chk("pass", 64'(pass), 64'(e.pass));
                    chk("err_ovf", 64'(err_ovf), 64'(e.ovf));
                    chk("word_count", 64'(word_count), 64'(e.wc));
                    chk("checksum", 64'(checksum), 64'(e.ck));
                    held = e;
                end
            end else begin
                if (cyc == last_acc_cyc) chk("missing_done", 64'(done), 64'(1));
                chk("hold_pass", 64'(pass), 64'(held.pass));
                chk("hold_err_ovf", 64'(err_ovf), 64'(held.ovf));
                chk("hold_word_count", 64'(word_count), 64'(held.wc));
                chk("hold_checksum", 64'(checksum), 64'(held.ck));
            end
        end
    end

    // Driver sync point: just after the falling edge, after the monitor has sampled.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = $urandom;
        repeat (n) step();
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input logic l, input exp_t e);
        exp_t ee;
        int   w;
        ee = e;
        w  = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready) begin
            if (w == 50) begin
                chk("ready_timeout", 64'(in_ready), 64'(1));
                in_valid = 1'b0;
                return;
            end
            step();
            w++;
        end
        if (l) begin
            ee.cyc = cyc + 1;
            sb.push_back(ee);
            last_acc_cyc = cyc + 1;
        end
        step();
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] ck, input bit gaps);
        exp_t e;
        e = model(ck);
        foreach (pay[i]) begin
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            send_word(pay[i], 1'b0, e);
        end
        if (gaps && $urandom_range(0, 3) == 0) idle(1);
        send_word(ck, 1'b1, e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t             dummy;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] ck;
        int               n;

        dummy = model('0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        step();

        // Good frame.
        pay = '{32'h0000_00FF, 32'h0000_FF00};
        send_frame(32'h0000_FFFF, 1'b0);
        idle(2);

        // Reset mid-ACCUM: partial frame dropped, no done.
        pay = '{32'hAAAA_0000, 32'h0000_BBBB};
        foreach (pay[i]) send_word(pay[i], 1'b0, dummy);
        idle(0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        step();
        idle(1);

        // Bad frame.
        pay = '{32'h1234_5678};
        send_frame(32'h1234_5679, 1'b0);
        idle(1);

        // Empty frames.
        pay.delete();
        send_frame(32'h0, 1'b0);
        idle(1);
        send_frame(32'h1, 1'b0);
        idle(1);

        // Overflow: 6 payload words with MAX_WORDS=4.
        pay = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20};
        send_frame(32'h3F, 1'b0);
        idle(1);

        // Back-to-back frames with valid held high across REPORT.
        pay = '{32'hDEAD_BEEF, 32'h0F0F_0F0F};
        send_frame(32'hDEAD_BEEF ^ 32'h0F0F_0F0F, 1'b0);
        pay = '{32'hCAFE_0001, 32'h0000_1234, 32'h5555_AAAA};
        send_frame(32'hCAFE_0001 ^ 32'h0000_1234, 1'b0);
        idle(2);

        // Random frames, including empty, full and overflowing payloads.
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(0, 7);
            pay.delete();
            x = '0;
            for (int i = 0; i < n; i++) begin
                pay.push_back($urandom);
                x = x ^ pay[i];
            end
            ck = ($urandom_range(0, 1) == 1) ? x : WIDTH'($urandom);
            send_frame(ck, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end

        idle(4);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
